// File: rtl/reg_bank_rd.sv
// reg_bank_rd: 14-entry architectural register bank with a registered read port.
// Ports: clk, rst_n (sync, active-low), wtr_vec/bus_in write, inc_sel/inc_en
//        increment, rd_sel/rd_en read -> bus_out/rd_valid/rd_err, wr_err,
//        reg_a/reg_b live copies of A and B.
module reg_bank_rd #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [13:0]       wtr_vec,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [4:0]        inc_sel,
    input  logic              inc_en,
    input  logic [4:0]        rd_sel,
    input  logic              rd_en,
    output logic [DATA_W-1:0] bus_out,
    output logic              rd_valid,
    output logic              rd_err,
    output logic              wr_err,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b
);

    localparam int NREG = 14;
    localparam int IDX_A = 11;
    localparam int IDX_B = 12;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;
    logic              wr_err_q, wr_err_d;

    logic              wr_any;
    logic              wr_one;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_data;

    // x & (x-1) clears the lowest set bit; zero result means at most one bit.
    always_comb begin
        wr_any = |wtr_vec;
        wr_one = wr_any && ((wtr_vec & (wtr_vec - 14'd1)) == 14'd0);
    end

    // Write is applied after the increment so a same-register write wins.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (inc_en && (inc_sel == 5'(i + 1))) begin
                regs_d[i] = regs_q[i] + 1'b1;
            end
            if (wr_one && wtr_vec[i]) begin
                regs_d[i] = bus_in;
            end
        end
    end

    always_comb begin
        rd_ok   = rd_en && (rd_sel >= 5'd1) && (rd_sel <= 5'd14);
        rd_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_sel == 5'(i + 1)) begin
                rd_data = regs_q[i];
            end
        end
        bus_out_d  = rd_ok ? rd_data : bus_out_q;
        rd_valid_d = rd_ok;
        rd_err_d   = rd_en && !rd_ok;
        wr_err_d   = wr_any && !wr_one;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            bus_out_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            bus_out_q  <= bus_out_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign bus_out  = bus_out_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign wr_err   = wr_err_q;
    assign reg_a    = regs_q[IDX_A];
    assign reg_b    = regs_q[IDX_B];

endmodule
